// File: rtl/sseg_scan_decoder_amisha.sv
// rtl/sseg_scan_decoder_amisha.sv - scanned 4-digit seven-segment bus readback decoder
// Define SSEG_DEC_SYNC_EN to insert a two-flop synchronizer ahead of the sample register.
module sseg_scan_decoder_amisha #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk_amisha,
    input  logic        reset_amisha,
    input  logic [3:0]  an_amisha,
    input  logic [7:0]  sseg_amisha,
    output logic [15:0] hex_amisha,
    output logic [3:0]  dp_out_amisha,
    output logic [3:0]  valid_amisha,
    output logic [3:0]  err_amisha,
    output logic        frame_done_amisha,
    output logic        timeout_amisha
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_LAST  = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX   = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t      state, state_next;
    logic [SW-1:0] cnt, cnt_next;
    logic [TW-1:0] tcnt;
    logic [11:0] samp, samp_prev;
    logic [3:0]  an_s, sel, cap_set;
    logic        an_onehot, chg, capture;
    logic [3:0]  dec_nib;
    logic        dec_legal;

`ifdef SSEG_DEC_SYNC_EN
    logic [11:0] sync1, sync2;
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            sync1 <= '1;
            sync2 <= '1;
            samp  <= '1;
        end else begin
            sync1 <= {an_amisha, sseg_amisha};
            sync2 <= sync1;
            samp  <= sync2;
        end
    end
`else
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) samp <= '1;
        else              samp <= {an_amisha, sseg_amisha};
    end
`endif

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) samp_prev <= '1;
        else              samp_prev <= samp;
    end

    assign an_s      = samp[11:8];
    assign sel       = ~an_s;
    assign an_onehot = $onehot(sel);
    assign chg       = (samp != samp_prev);

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Any change of the sample restarts qualification at 1, counting the new value's first cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (an_onehot) begin
                    state_next = SETTLE;
                    cnt_next   = SW'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            SETTLE, HOLD: begin
                if (chg) begin
                    state_next = an_onehot ? SETTLE : IDLE;
                    cnt_next   = an_onehot ? SW'(1) : '0;
                end else if (state == SETTLE) begin
                    if (cnt >= STABLE_LAST) begin
                        state_next = HOLD;
                        cnt_next   = STABLE_MAX;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        capture = (state == SETTLE) && !chg && (cnt >= STABLE_LAST);
    end

    always_comb begin
        dec_nib   = '0;
        dec_legal = 1'b1;
        case (samp[6:0])
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    // A capture takes priority over the timeout terminal count in the same cycle.
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            hex_amisha        <= '0;
            dp_out_amisha     <= '0;
            valid_amisha      <= '0;
            err_amisha        <= '0;
            frame_done_amisha <= 1'b0;
            timeout_amisha    <= 1'b0;
            cap_set           <= '0;
            tcnt              <= '0;
        end else begin
            frame_done_amisha <= 1'b0;
            if (capture) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) begin
                        dp_out_amisha[i] <= samp[7];
                        valid_amisha[i]  <= dec_legal;
                        err_amisha[i]    <= !dec_legal && (samp[6:0] != 7'h7F);
                        if (dec_legal) hex_amisha[4*i +: 4] <= dec_nib;
                    end
                end
                cap_set        <= cap_set | sel;
                tcnt           <= '0;
                timeout_amisha <= 1'b0;
            end else begin
                if (cap_set == 4'hF) begin
                    frame_done_amisha <= 1'b1;
                    cap_set           <= '0;
                end
                if (tcnt == TIMEOUT_LAST) begin
                    timeout_amisha <= 1'b1;
                    valid_amisha   <= '0;
                    cap_set        <= '0;
                end
                if (tcnt != TIMEOUT_MAX) tcnt <= tcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sseg_scan_decoder_amisha.sv
// tb/tb_sseg_scan_decoder_amisha.sv - scoreboard bench for sseg_scan_decoder_amisha
module tb_sseg_scan_decoder_amisha;
    localparam int STABLE = 16;
    localparam int TMO    = 64;
`ifdef SSEG_DEC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam logic [6:0] PAT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic        clk_amisha = 1'b0;
    logic        reset_amisha = 1'b1;
    logic [3:0]  an_amisha = 4'hF;
    logic [7:0]  sseg_amisha = 8'hFF;
    logic [15:0] hex_amisha;
    logic [3:0]  dp_out_amisha, valid_amisha, err_amisha;
    logic        frame_done_amisha, timeout_amisha;

    sseg_scan_decoder_amisha #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_amisha(clk_amisha), .reset_amisha(reset_amisha),
        .an_amisha(an_amisha), .sseg_amisha(sseg_amisha),
        .hex_amisha(hex_amisha), .dp_out_amisha(dp_out_amisha),
        .valid_amisha(valid_amisha), .err_amisha(err_amisha),
        .frame_done_amisha(frame_done_amisha), .timeout_amisha(timeout_amisha));

    always #5 clk_amisha = ~clk_amisha;

    typedef struct { int due; int idx; int kind; logic [3:0] nib; logic dp; } cap_t;
    cap_t sb[$];

    int errors = 0, checks = 0, t = 0, last_cap_t = 0, frame_due = -1, fd_cnt = 0;
    logic [15:0] m_hex = '0;
    logic [3:0]  m_dp = '0, m_valid = '0, m_err = '0, m_set = '0;
    logic        m_fd = 1'b0, m_to = 1'b0;

    // kind: 0 legal hex, 1 blank, 2 illegal
    function automatic int classify(input logic [6:0] p, output logic [3:0] nib);
        nib = '0;
        for (int i = 0; i < 16; i++)
            if (PAT[i] == p) begin
                nib = 4'(i);
                return 0;
            end
        return (p == 7'h7F) ? 1 : 2;
    endfunction

    task automatic push_digit(input logic [3:0] an_v, input logic [7:0] seg_v);
        cap_t c;
        an_amisha   = an_v;
        sseg_amisha = seg_v;
        c.due  = t + 1 + STABLE + LAT;
        c.idx  = 0;
        for (int i = 0; i < 4; i++) if (!an_v[i]) c.idx = i;
        c.kind = classify(seg_v[6:0], c.nib);
        c.dp   = seg_v[7];
        sb.push_back(c);
    endtask

    // Advances one clock and moves the reference model to the post-edge state.
    task automatic tick();
        cap_t c;
        @(posedge clk_amisha);
        t++;
        m_fd = 1'b0;
        if (reset_amisha) begin
            sb.delete();
            m_hex = '0; m_dp = '0; m_valid = '0; m_err = '0; m_set = '0; m_to = 1'b0;
            last_cap_t = t;
            frame_due  = -1;
        end else if (sb.size() > 0 && sb[0].due == t) begin
            c = sb.pop_front();
            m_dp[c.idx] = c.dp;
            if (c.kind == 0) m_hex[4*c.idx +: 4] = c.nib;
            m_valid[c.idx] = (c.kind == 0);
            m_err[c.idx]   = (c.kind == 2);
            m_set[c.idx]   = 1'b1;
            if (m_set == 4'hF) frame_due = t + 1;
            last_cap_t = t;
            m_to = 1'b0;
        end else begin
            if (t == frame_due) begin
                m_fd  = 1'b1;
                m_set = '0;
            end
            if (!m_to && (t - last_cap_t == TMO)) begin
                m_to    = 1'b1;
                m_valid = '0;
                m_set   = '0;
            end
        end
        #1;
        fd_cnt += int'(frame_done_amisha);
    endtask

    task automatic test_reset();
        reset_amisha = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if ({hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha} !== 30'h0) begin
                errors++;
                $display("FAIL reset_values got %h want 0", {hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha});
            end
        end
        reset_amisha = 1'b0;
    endtask

    task automatic test_single();
        int fd0 = fd_cnt;
        push_digit(4'b1110, 8'h81);
        repeat (STABLE + 4) begin
            tick();
            checks++;
            if ({hex_amisha, dp_out_amisha, valid_amisha, err_amisha} !== {m_hex, m_dp, m_valid, m_err}) begin
                errors++;
                $display("FAIL single_out t=%0d got %h want %h", t, {hex_amisha, dp_out_amisha, valid_amisha, err_amisha}, {m_hex, m_dp, m_valid, m_err});
            end
        end
        checks++;
        if ({hex_amisha[3:0], dp_out_amisha[0], valid_amisha[0], err_amisha[0]} !== 7'b0000110) begin
            errors++;
            $display("FAIL single_digit0 got %b want 0000110", {hex_amisha[3:0], dp_out_amisha[0], valid_amisha[0], err_amisha[0]});
        end
        checks++;
        if (fd_cnt - fd0 != 0) begin
            errors++;
            $display("FAIL single_no_frame got %0d pulses want 0", fd_cnt - fd0);
        end
    endtask

    task automatic test_frame();
        int fd0 = fd_cnt;
        for (int d = 0; d < 4; d++) begin
            push_digit(~(4'b0001 << d), {1'b0, PAT[10 + d]});
            repeat (32) begin
                tick();
                checks++;
                if ({hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha} !== {m_hex, m_dp, m_valid, m_err, m_fd, m_to}) begin
                    errors++;
                    $display("FAIL frame_out t=%0d got %h want %h", t, {hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha}, {m_hex, m_dp, m_valid, m_err, m_fd, m_to});
                end
            end
        end
        checks++;
        if ({hex_amisha, valid_amisha} !== {16'hDCBA, 4'hF}) begin
            errors++;
            $display("FAIL frame_final got %h want DCBAF", {hex_amisha, valid_amisha});
        end
        checks++;
        if (fd_cnt - fd0 != 1) begin
            errors++;
            $display("FAIL frame_pulses got %0d want 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_illegal();
        push_digit(4'b1011, {1'b0, 7'b1111110});
        repeat (20) begin
            tick();
            checks++;
            if ({hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha} !== {m_hex, m_dp, m_valid, m_err, m_fd, m_to}) begin
                errors++;
                $display("FAIL illegal_out t=%0d got %h want %h", t, {hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha}, {m_hex, m_dp, m_valid, m_err, m_fd, m_to});
            end
        end
        checks++;
        if ({err_amisha[2], valid_amisha[2], hex_amisha[11:8]} !== 6'b10_1100) begin
            errors++;
            $display("FAIL illegal_digit2 got %b want 101100", {err_amisha[2], valid_amisha[2], hex_amisha[11:8]});
        end
        push_digit(4'b1011, {1'b0, 7'b1111111});
        repeat (20) begin
            tick();
            checks++;
            if ({hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha} !== {m_hex, m_dp, m_valid, m_err, m_fd, m_to}) begin
                errors++;
                $display("FAIL blank_out t=%0d got %h want %h", t, {hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha}, {m_hex, m_dp, m_valid, m_err, m_fd, m_to});
            end
        end
        checks++;
        if ({err_amisha[2], valid_amisha[2], hex_amisha[11:8]} !== 6'b00_1100) begin
            errors++;
            $display("FAIL blank_digit2 got %b want 001100", {err_amisha[2], valid_amisha[2], hex_amisha[11:8]});
        end
    endtask

    task automatic test_glitch();
        repeat (3) begin
            an_amisha   = 4'b1101;
            sseg_amisha = {1'b0, 7'b0001111};
            for (int n = 0; n < STABLE; n++) begin
                if (n == STABLE - 2) sseg_amisha = {1'b0, 7'b0001110};
                if (n == STABLE - 1) break;
                tick();
                checks++;
                if ({hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha} !== {m_hex, m_dp, m_valid, m_err, m_fd, m_to}) begin
                    errors++;
                    $display("FAIL glitch_out t=%0d got %h want %h", t, {hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha}, {m_hex, m_dp, m_valid, m_err, m_fd, m_to});
                end
            end
        end
        checks++;
        if ({valid_amisha[1], hex_amisha[7:4]} !== 5'b1_1011) begin
            errors++;
            $display("FAIL glitch_digit1 got %b want 11011", {valid_amisha[1], hex_amisha[7:4]});
        end
    endtask

    task automatic test_timeout();
        for (int d = 0; d < 5; d++) begin
            if (d < 4) push_digit(~(4'b0001 << d), {1'b0, PAT[d + 1]});
            else begin
                an_amisha   = 4'hF;
                sseg_amisha = 8'hFF;
            end
            repeat ((d < 4) ? 20 : TMO + 5) begin
                tick();
                checks++;
                if ({hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha} !== {m_hex, m_dp, m_valid, m_err, m_fd, m_to}) begin
                    errors++;
                    $display("FAIL timeout_out t=%0d got %h want %h", t, {hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha}, {m_hex, m_dp, m_valid, m_err, m_fd, m_to});
                end
            end
        end
        checks++;
        if ({timeout_amisha, valid_amisha, hex_amisha} !== {1'b1, 4'h0, 16'h4321}) begin
            errors++;
            $display("FAIL timeout_set got %h want 104321", {timeout_amisha, valid_amisha, hex_amisha});
        end
        push_digit(4'b1110, {1'b0, PAT[5]});
        repeat (20) begin
            tick();
            checks++;
            if ({hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha} !== {m_hex, m_dp, m_valid, m_err, m_fd, m_to}) begin
                errors++;
                $display("FAIL recover_out t=%0d got %h want %h", t, {hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha}, {m_hex, m_dp, m_valid, m_err, m_fd, m_to});
            end
        end
        checks++;
        if ({timeout_amisha, valid_amisha, hex_amisha} !== {1'b0, 4'h1, 16'h4325}) begin
            errors++;
            $display("FAIL timeout_clear got %h want 014325", {timeout_amisha, valid_amisha, hex_amisha});
        end
    endtask

    task automatic test_reset_mid_settle();
        push_digit(4'b0111, {1'b1, PAT[14]});
        repeat (8) tick();
        reset_amisha = 1'b1;
        tick();
        checks++;
        if ({hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha} !== 30'h0) begin
            errors++;
            $display("FAIL midreset_values got %h want 0", {hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha});
        end
        reset_amisha = 1'b0;
        push_digit(4'b0111, {1'b1, PAT[14]});
        repeat (STABLE + 4) begin
            tick();
            checks++;
            if ({hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha} !== {m_hex, m_dp, m_valid, m_err, m_fd, m_to}) begin
                errors++;
                $display("FAIL midreset_out t=%0d got %h want %h", t, {hex_amisha, dp_out_amisha, valid_amisha, err_amisha, frame_done_amisha, timeout_amisha}, {m_hex, m_dp, m_valid, m_err, m_fd, m_to});
            end
        end
        checks++;
        if ({hex_amisha, dp_out_amisha, valid_amisha, err_amisha} !== {16'hE000, 4'h8, 4'h8, 4'h0}) begin
            errors++;
            $display("FAIL midreset_capture got %h want E000880", {hex_amisha, dp_out_amisha, valid_amisha, err_amisha});
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame();
        test_illegal();
        test_glitch();
        test_timeout();
        test_reset_mid_settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
